// File: rtl/bsg_locking_arb_pkg.sv
// Purpose : shared types and constants for the locking-arbiter release logic.
// Latency : n/a (package only).
// Backpressure: n/a; holds the FSM state enum and the header/last-beat encoding.
package bsg_locking_arb_pkg;

    // Release FSM: IDLE waits for a header beat, LOCKED tracks the body beats.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // A header whose length field equals this value is a single-beat packet.
    localparam int unsigned single_beat_len_lp = 0;

    // beats_left value at which the accepted beat is the packet's last.
    localparam int unsigned last_beat_left_lp = 1;

endpackage

// File: rtl/bsg_lock_idle_timer.sv
// Purpose : counts consecutive idle cycles of a locked packet and flags expiry.
// Latency : expire_o is combinational; it rises in the timeout_p-th idle cycle.
// Backpressure: none; any non-idle cycle or an expiry restarts the count.
// Ports   : clk_i/reset_n_i clock and async active-low reset; idle_i marks a
//           locked cycle without a grant; expire_o requests a forced release.
module bsg_lock_idle_timer #(
    parameter int timeout_p = 255
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic idle_i,
    output logic expire_o
);

    localparam int cnt_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;

    // Holds the number of idle cycles already completed, so the cycle in which
    // the count reaches timeout_p is the one where the register shows timeout_p-1.
    logic [cnt_width_lp-1:0] cnt_q;

    assign expire_o = idle_i && (cnt_q == cnt_width_lp'(timeout_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else if (!idle_i || expire_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + cnt_width_lp'(1);
        end
    end

endmodule

// File: rtl/bsg_locking_arb_release.sv
// Purpose : tracks packet boundaries behind a locking arbiter and pulses unlock on the last beat.
// Latency : unlock_o is combinational (same cycle as the last grant); status outputs are registered.
// Backpressure: none; a cycle with no grant simply holds state (optional idle timeout forces release).
// Ports   : clk_i, reset_n_i (async active-low); grants_i grant vector, len_i header length;
//           unlock_o release pulse, locked_o packet in progress, owner_o one-hot owner,
//           beats_left_o beats still expected, err_o sticky protocol error, timeout_o sticky forced release.
// Config  : define BSG_LOCKING_ARB_RELEASE_TIMEOUT_EN to enable the idle-timeout release.
module bsg_locking_arb_release
    import bsg_locking_arb_pkg::*;
#(
    parameter int inputs_p    = 4,    // arbiter width; always set by the instantiating arbiter
    parameter int len_width_p = 4,
    parameter int timeout_p   = 255
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [inputs_p-1:0]    grants_i,
    input  logic [len_width_p-1:0] len_i,
    output logic                   unlock_o,
    output logic                   locked_o,
    output logic [inputs_p-1:0]    owner_o,
    output logic [len_width_p-1:0] beats_left_o,
    output logic                   err_o,
    output logic                   timeout_o
);

    lock_state_e              state_q, state_d;
    logic [inputs_p-1:0]      owner_q, owner_d;
    logic [len_width_p-1:0]   left_q, left_d;
    logic                     err_q, err_d;
    logic                     to_q, to_d;
    logic                     unlock_raw;
    logic                     any_grant;
    logic                     grant_bad;
    logic                     timeout_fire;

    assign any_grant = |grants_i;

    // A stray grant is flagged but still counted as the owner's beat, so the
    // packet framing stays aligned with what the arbiter actually forwarded.
    assign grant_bad = any_grant &&
                       (!$onehot(grants_i) || ((state_q == LOCKED) && (grants_i != owner_q)));

`ifdef BSG_LOCKING_ARB_RELEASE_TIMEOUT_EN
    bsg_lock_idle_timer #(
        .timeout_p (timeout_p)
    ) idle_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .idle_i    ((state_q == LOCKED) && !any_grant),
        .expire_o  (timeout_fire)
    );
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        left_d     = left_q;
        err_d      = err_q | grant_bad;
        to_d       = to_q;
        unlock_raw = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_grant) begin
                    if (len_i == len_width_p'(single_beat_len_lp)) begin
                        // Header is also the last beat: release at once, owner stays clear.
                        unlock_raw = 1'b1;
                        left_d     = '0;
                    end else begin
                        state_d = LOCKED;
                        owner_d = grants_i;
                        left_d  = len_i;
                    end
                end
            end
            LOCKED: begin
                if (any_grant) begin
                    // Never decrement through zero; LOCKED always holds a nonzero count.
                    left_d = (left_q == '0) ? '0 : left_q - len_width_p'(1);
                    if (left_q == len_width_p'(last_beat_left_lp)) begin
                        unlock_raw = 1'b1;
                        state_d    = IDLE;
                        owner_d    = '0;
                    end
                end else if (timeout_fire) begin
                    unlock_raw = 1'b1;
                    state_d    = IDLE;
                    owner_d    = '0;
                    left_d     = '0;
                    to_d       = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                left_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            left_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            left_q  <= left_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // Gate with reset so a grant seen while in reset never releases the arbiter.
    assign unlock_o     = reset_n_i & unlock_raw;
    assign locked_o     = (state_q == LOCKED);
    assign owner_o      = owner_q;
    assign beats_left_o = left_q;
    assign err_o        = err_q;
    assign timeout_o    = to_q;

endmodule
